// File: rtl/ask_demodulation.sv
// ASK demodulator: locks onto a carrier burst and integrates |sample - MID| over
// BIT_LEN samples per bit, slicing the per-bit energy against ENERGY_TH.
module ask_demodulation #(
   parameter int          BIT_LEN   = 512,
   parameter logic [15:0] MID       = 16'h2710,
   parameter logic [15:0] AMP_TH    = 16'd2000,
   parameter int          ENERGY_TH = 512000,
   parameter int          MAX_ZEROS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] sample_in,
   output logic        dout,
   output logic        dout_valid,
   output logic        locked
);

   localparam int CNT_W = $clog2(BIT_LEN);
   localparam int ACC_W = 16 + CNT_W;
   localparam int ZW    = $clog2(MAX_ZEROS + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   bit_cnt;
   logic [ZW-1:0]      zero_cnt;
   logic               hold_off;

   logic signed [16:0] diff;
   logic signed [16:0] diff_neg;
   logic [15:0]        dev;
   logic [ACC_W-1:0]   total;
   logic               bit_val;
   logic               bit_end;

   always_comb begin
      diff     = $signed({1'b0, sample_in}) - $signed({1'b0, MID});
      diff_neg = -diff;
      dev      = diff[16] ? diff_neg[15:0] : diff[15:0];
      total    = acc + ACC_W'(dev);
      bit_val  = (total >= ACC_W'(ENERGY_TH));
      bit_end  = (bit_cnt == CNT_W'(BIT_LEN - 1));
   end

   // hold_off blocks a trigger on the cycle IDLE is re-entered after lock loss.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         locked     <= 1'b0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         acc        <= '0;
         bit_cnt    <= '0;
         zero_cnt   <= '0;
         hold_off   <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (!enable) begin
            state    <= IDLE;
            locked   <= 1'b0;
            acc      <= '0;
            bit_cnt  <= '0;
            zero_cnt <= '0;
            hold_off <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  hold_off <= 1'b0;
                  if (!hold_off && (dev > AMP_TH)) begin
                     state   <= RUN;
                     locked  <= 1'b1;
                     acc     <= ACC_W'(dev);
                     bit_cnt <= CNT_W'(1);
                  end
               end
               RUN: begin
                  if (bit_end) begin
                     dout       <= bit_val;
                     dout_valid <= 1'b1;
                     acc        <= '0;
                     bit_cnt    <= '0;
                     if (bit_val) begin
                        zero_cnt <= '0;
                     end else if (zero_cnt == ZW'(MAX_ZEROS - 1)) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        zero_cnt <= '0;
                        hold_off <= 1'b1;
                     end else begin
                        zero_cnt <= zero_cnt + 1'b1;
                     end
                  end else begin
                     acc     <= total;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ask_demodulation.sv
// Directed bench for ask_demodulation: expected pulses (step index + bit) are
// queued as bits are sent and matched against dout_valid/dout each cycle.
module tb_ask_demodulation;

   localparam int          BIT_LEN = 512;
   localparam logic [15:0] MID     = 16'h2710;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] sample_in;
   logic        dout;
   logic        dout_valid;
   logic        locked;

   logic [32:0] exp_q[$];
   logic [31:0] cyc;
   int          checks;
   int          failures;

   ask_demodulation dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .sample_in  (sample_in),
      .dout       (dout),
      .dout_valid (dout_valid),
      .locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] carrier(input int i);
      return (i % 2 == 1) ? 16'h1388 : 16'h3A98;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic [32:0] e;
      if (exp_q.size() != 0) begin
         checks++;
         assert (exp_q[0][32:1] >= cyc) else begin
            failures++;
            $error("FAIL missed_pulse step=%0d observed=none expected_at=%0d", cyc, exp_q[0][32:1]);
            void'(exp_q.pop_front());
         end
      end
      if (dout_valid) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_pulse step=%0d observed_dout=%0b expected=no_pulse", cyc, dout);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({cyc, dout} === e) else begin
               failures++;
               $error("FAIL pulse observed step=%0d dout=%0b expected step=%0d dout=%0b",
                      cyc, dout, e[32:1], e[0]);
            end
         end
      end
   endtask

   // Drive one sample, let the edge happen, then observe #1 later.
   task automatic step(input logic en, input logic [15:0] s);
      enable    = en;
      sample_in = s;
      @(posedge clk);
      #1;
      monitor();
      cyc++;
   endtask

   task automatic send_bit(input logic b, input logic expect_pulse);
      if (expect_pulse) exp_q.push_back({cyc + 32'(BIT_LEN - 1), b});
      for (int i = 0; i < BIT_LEN; i++) step(1'b1, b ? carrier(i) : MID);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      reset     = 1'b1;
      enable    = 1'b0;
      sample_in = MID;

      // Reset held two cycles with a strong input present
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 16'h4000);
         chk("reset_dout", 32'(dout), 32'd0);
         chk("reset_valid", 32'(dout_valid), 32'd0);
         chk("reset_locked", 32'(locked), 32'd0);
      end
      reset = 1'b0;
      exp_q.push_back({cyc + 32'd511, 1'b1});
      step(1'b1, 16'h4000);
      chk("post_reset_locked", 32'(locked), 32'd1);
      for (int i = 0; i < 511; i++) step(1'b1, 16'h4000);
      chk("post_reset_bit_dout", 32'(dout), 32'd1);
      for (int i = 0; i < 100; i++) step(1'b1, 16'h4000);
      chk("midbit_locked", 32'(locked), 32'd1);
      reset = 1'b1;
      step(1'b1, MID);
      chk("midbit_reset_dout", 32'(dout), 32'd0);
      chk("midbit_reset_valid", 32'(dout_valid), 32'd0);
      chk("midbit_reset_locked", 32'(locked), 32'd0);
      reset = 1'b0;

      // Idle line: baseline only
      for (int i = 0; i < 2000; i++) begin
         step(1'b1, MID);
         chk("idle_locked", 32'(locked), 32'd0);
      end

      // Single '1' then silence until lock is lost on the eighth zero
      send_bit(1'b1, 1'b1);
      chk("single_bit_locked", 32'(locked), 32'd1);
      for (int k = 0; k < 8; k++) begin
         send_bit(1'b0, 1'b1);
         chk("zero_run_locked", 32'(locked), (k < 7) ? 32'd1 : 32'd0);
      end
      chk("lock_loss_valid", 32'(dout_valid), 32'd1);
      chk("lock_loss_dout", 32'(dout), 32'd0);

      // No trigger on the cycle IDLE is entered, trigger on the next
      step(1'b1, 16'h3A98);
      chk("reentry_no_trigger", 32'(locked), 32'd0);

      // Pattern 1,0,1,1
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      chk("pattern_locked", 32'(locked), 32'd1);
      chk("pattern_last_dout", 32'(dout), 32'd1);

      // Abort mid-bit at bit counter 300
      for (int i = 0; i < 300; i++) step(1'b1, carrier(i));
      step(1'b0, carrier(300));
      chk("abort_locked", 32'(locked), 32'd0);
      step(1'b0, carrier(301));
      step(1'b0, carrier(302));
      chk("abort_dout_held", 32'(dout), 32'd1);
      chk("abort_idle_locked", 32'(locked), 32'd0);

      // Relock after abort
      send_bit(1'b1, 1'b1);
      chk("relock_locked", 32'(locked), 32'd1);

      // Enable drops exactly on the bit-end sample: no pulse
      for (int i = 0; i < BIT_LEN - 1; i++) step(1'b1, carrier(i));
      step(1'b0, carrier(BIT_LEN - 1));
      chk("bitend_abort_locked", 32'(locked), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b0, carrier(i));
      chk("bitend_abort_dout", 32'(dout), 32'd1);

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ask_demodulation.md
ASK_DEMODULATION -- requirements
Module: ask_demodulation

Interface
REQ-001 SHALL have parameter BIT_LEN, default 512, samples per bit (power of two, >= 4).
REQ-002 SHALL have parameter MID, default 16'h2710, carrier baseline and idle level.
REQ-003 SHALL have parameter AMP_TH, default 16'd2000, per-sample deviation that triggers lock.
REQ-004 SHALL have parameter ENERGY_TH, default 512000, per-bit accumulated deviation threshold for a '1'.
REQ-005 SHALL have parameter MAX_ZEROS, default 8, consecutive '0' bits before lock loss.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  demodulator enable; low forces IDLE.
REQ-009 SHALL have port sample_in  input  16  unsigned ASK sample, one per clk.
REQ-010 SHALL have port dout  output  1  last recovered bit, held until the next bit.
REQ-011 SHALL have port dout_valid  output  1  one-cycle pulse per recovered bit.
REQ-012 SHALL have port locked  output  1  high while in RUN.

Function
REQ-013 SHALL compute dev = |sample_in - MID| from a 17-bit signed difference; the result always fits 16 bits, no saturation.
REQ-014 SHALL use an accumulator of 16+log2(BIT_LEN) bits (25 by default); overflow is impossible and SHALL NOT be handled.
REQ-015 SHALL use a bit counter of log2(BIT_LEN) bits and a zero-run counter wide enough for MAX_ZEROS.
REQ-016 SHALL implement two states, IDLE and RUN; locked is 1 exactly when the state is RUN.
REQ-017 IDLE: when enable=1 and dev > AMP_TH, SHALL go to RUN, load acc=dev, and set bit counter=1 (triggering sample = sample 0 of bit 0).
REQ-018 RUN: each cycle SHALL add dev to acc and increment the bit counter.
REQ-019 RUN: on the sample with bit counter = BIT_LEN-1, the total T = acc + dev SHALL be compared against ENERGY_TH (T >= ENERGY_TH gives '1').
REQ-020 On that cycle the registered result SHALL set dout, pulse dout_valid for one cycle (visible the next cycle), clear acc to 0, and wrap the counter to 0.
REQ-021 Bit n's dout_valid SHALL appear exactly BIT_LEN*(n+1) cycles after the trigger edge; pulses are spaced exactly BIT_LEN cycles apart.
REQ-022 A '1' bit SHALL clear the zero-run counter; a '0' bit SHALL increment it.
REQ-023 On the MAX_ZEROS-th consecutive '0', that bit SHALL still be emitted with dout_valid, and the state SHALL return to IDLE (locked=0 on the same cycle dout_valid is high).
REQ-024 IDLE SHALL NOT re-trigger on the cycle it is entered; triggering resumes the following cycle.
REQ-025 enable=0 in any state SHALL go to IDLE next edge, clearing acc, the bit counter and the zero-run counter and suppressing dout_valid; dout SHALL keep its value.
REQ-026 enable falling on a bit-end cycle: enable SHALL win and no dout_valid pulse occurs.
REQ-027 dout_valid SHALL never be high in IDLE except on the lock-loss cycle defined in REQ-023.

Reset
REQ-028 reset=1 at a clock edge SHALL set state=IDLE, dout=0, dout_valid=0, locked=0, acc=0, and both counters to 0, overriding enable and all other inputs, including mid-bit.
REQ-029 On the first cycle after reset deasserts, the block SHALL be able to trigger if the REQ-017 conditions hold.

Verification
REQ-030 Reset: reset=1 for 2 cycles, enable=1, sample_in=16'h4000 -> dout=0, dout_valid=0, locked=0 during and on the first cycle after reset; locked=1 the next cycle.
REQ-031 Idle line: enable=1, sample_in=16'h2710 for 2000 cycles -> locked=0 and no dout_valid.
REQ-032 Single bit: alternating 16'h3A98/16'h1388 for 512 cycles, then 16'h2710 -> locked rises after the first sample; dout_valid at +512 with dout=1 and at +1024 with dout=0.
REQ-033 Pattern 1,0,1,1 (carrier as REQ-032 for '1', 16'h2710 for '0') -> four pulses exactly 512 cycles apart, dout=1,0,1,1.
REQ-034 Lock loss: one '1' followed by constant 16'h2710 -> 9 dout_valid pulses (1 then eight 0s); locked=0 on the 9th pulse cycle; no further pulses.
REQ-035 Abort: enable driven to 0 at bit counter 300 during a '1' -> no pulse for that bit, locked=0 next cycle; enable back to 1 with carrier -> relock, and the first pulse arrives 512 cycles after the trigger with dout=1.
